// File: rtl/snake_pkg.sv
// Shared encodings for the snake input path.
// Directions, controller states and the reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_input_ctrl_btn_debounce.sv
// One button: 2-flop sync, stability counter, debounced level
// and a single-cycle press pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          in_pressed;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign in_pressed = raw ^ ACTIVE_LOW;

  always_comb begin
    sync1_d  = in_pressed;
    sync2_d  = sync1_q;
    prev_d   = stable_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = stable_q & ~prev_q;

endmodule

// File: rtl/snake_input_ctrl.sv
// Button conditioning and start/run/over control for the snake game:
// debounced presses become a committed direction plus a step tick.
module snake_input_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 5000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       game_tick,
  output logic       running,
  output logic [3:0] btn_state
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [3:0] raw_btn;
  logic [3:0] press;
  logic       any_press;
  dir_e       sel;
  logic       tick_last;

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  dir_e       pend_q, pend_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  assign raw_btn = {up, down, left, right};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_db (
      .clk   (clock),
      .rst_n (resetn),
      .raw   (raw_btn[i]),
      .level (btn_state[i]),
      .press (press[i])
    );
  end

  assign any_press = |press;

  always_comb begin
    sel = DIR_RIGHT;
    priority case (1'b1)
      press[3]: sel = DIR_UP;
      press[2]: sel = DIR_DOWN;
      press[1]: sel = DIR_LEFT;
      default:  sel = DIR_RIGHT;
    endcase
  end

  assign tick_last = (tcnt_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_WAIT: begin
        tcnt_d = '0;
        if (any_press) begin
          dir_d   = sel;
          pend_d  = sel;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (game_over) begin
          state_d = ST_OVER;
        end else begin
          tcnt_d = tick_last ? '0 : tcnt_q + 1'b1;
          if (tick_last) dir_d = pend_q;
          // reversal judged against the committed heading
          if (any_press && sel != opposite(dir_q)) pend_d = sel;
        end
      end
      ST_OVER: begin
        if (any_press) begin
          state_d = ST_WAIT;
          dir_d   = DIR_RIGHT;
          pend_d  = DIR_RIGHT;
          tcnt_d  = '0;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_WAIT;
      dir_q   <= DIR_RIGHT;
      pend_q  <= DIR_RIGHT;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign dir       = dir_q;
  assign running   = (state_q == ST_RUN);
  assign game_tick = (state_q == ST_RUN) && tick_last && !game_over;

endmodule

// File: doc/snake_input_ctrl.md
Name: snake_input_ctrl

Overview:
- Upstream conditioning stage for the snake game renderer: converts four raw push-buttons (up/down/left/right) into a clean, committed snake direction plus a periodic game-step pulse.
- Synchronises, debounces and edge-detects each button and rejects 180-degree reversals.
- Runs a start/run/over state machine.
- Outputs drive the VGA game controller's movement inputs, replacing the raw button wiring.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- TICK_CYCLES, 5000000: clock cycles per game step (10 Hz at 50 MHz).
- BTN_ACTIVE_LOW, 1: 1 = raw buttons read 0 when pressed (DE2 KEYs); 0 = active-high.

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-low reset
- up  in  1  raw asynchronous button
- down  in  1  raw asynchronous button
- left  in  1  raw asynchronous button
- right  in  1  raw asynchronous button
- game_over  in  1  level from game logic; collision detected
- dir  out  2  committed direction: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT
- game_tick  out  1  one-cycle pulse, one per game step
- running  out  1  high in RUN state
- btn_state  out  4  debounced pressed levels {up,down,left,right}, 1 = pressed

Behaviour:
- Reset: when resetn=0 at a clock edge, every register clears. Outputs after reset: dir=3 (RIGHT), pending=3, game_tick=0, running=0, btn_state=0. Sync flops load the released level. Debounce counters are 0. State is WAIT_START.
- Sync: two flops per button. Polarity is normalised per BTN_ACTIVE_LOW before the debouncer.
- Debounce (per button):
  - The counter increments each cycle that the sync output differs from the stable level.
  - The counter clears on any cycle where they match.
  - When the counter is at DEBOUNCE_CYCLES-1 and the levels still mismatch, the stable level toggles and the counter clears.
  - The counter width is sized for DEBOUNCE_CYCLES and never wraps.
- Press event: the stable level is registered (stable_d); press = stable & ~stable_d.
  - Latency: raw edge to pending update = DEBOUNCE_CYCLES+3 clock edges exactly.
  - Release events are ignored.
- Simultaneous presses in the same cycle: only the highest-priority press is considered. Priority is UP > DOWN > LEFT > RIGHT.
- Reversal rule: a press whose direction is the opposite of the committed dir (not of pending) is discarded. Opposite pairs are UP/DOWN and LEFT/RIGHT. Pressing the current dir is accepted and is a no-op.
- Pending: the last accepted press since the previous tick. A later accepted press overwrites it.
- State machine:
  - WAIT_START:
    - Tick counter held at 0; no ticks.
    - Any press (no reversal check) sets dir and pending to that direction and moves to RUN.
  - RUN:
    - Tick counter counts 0..TICK_CYCLES-1 and wraps.
    - game_tick=1 in the cycle the counter equals TICK_CYCLES-1.
    - On that same edge, dir <= pending.
    - If a press is accepted in the tick cycle, it updates pending but is not committed until the next tick.
    - game_over=1 moves to OVER at the next edge; this takes priority over a tick in the same cycle (no tick emitted, dir unchanged).
  - OVER:
    - No ticks; dir frozen.
    - Any press moves to WAIT_START, with dir and pending reset to RIGHT and the tick counter cleared. That press is consumed.
- Reset asserted mid-run or mid-debounce: everything returns to reset values at that edge. A button still held after reset only generates a press once its debounced level rises from released.

Decomposition:
- Shared package (snake_pkg): direction encodings DIR_UP=2'd0, DIR_DOWN=2'd1, DIR_LEFT=2'd2, DIR_RIGHT=2'd3; state encodings ST_WAIT=2'd0, ST_RUN=2'd1, ST_OVER=2'd2; an opposite-direction function (dir XOR 2'b01).
- One natural sub-module: btn_debounce (sync + counter + stable level + press pulse, parameterised by DEBOUNCE_CYCLES). It is instantiated four times.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, TICK_CYCLES=10, BTN_ACTIVE_LOW=1.)
1. Reset, then all buttons held high -> dir=3, running=0, game_tick never asserts for 100 cycles.
2. Start and commit:
   - Drive up=0 held; at edge 7 -> state RUN, dir=0, running=1.
   - First game_tick pulses 10 cycles after entry into RUN and lasts exactly 1 cycle.
3. Bounce rejection: toggle left every 3 cycles for 30 cycles -> btn_state[1] stays 0, no pending change.
4. Reversal handling, with dir=RIGHT in RUN:
   - Press LEFT -> discarded; next tick keeps dir=3.
   - Press UP then DOWN before the tick -> next tick commits dir=1 (DOWN is checked against committed RIGHT, so it is legal).
5. Simultaneous presses: up and right fall on the same cycle while dir=LEFT -> pending=UP; next tick gives dir=0.
6. Game over and restart:
   - game_over=1 coincident with tick count 9 -> no game_tick, state OVER, dir unchanged.
   - A later press -> WAIT_START with dir=3.
   - resetn=0 mid-RUN -> all outputs return to reset values on that edge.
